// File: rtl/mdu_execute_unit.sv
// RV32M multiply/divide unit for the EX stage: single-cycle multiply, 32-step
// restoring divide, and special-case divides that finish without iterating.
module mdu_execute_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      waddrE,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      waddrM
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r, next_state_s;
  logic [XLEN-1:0]   op_a_r, op_b_r, quo_r, rem_r, div_r, result_r;
  logic [1:0]        funct3_r;
  logic [4:0]        waddr_r, waddrm_r, cnt_r;
  logic              neg_q_r, neg_r_r, done_r, busy_r;

  logic              accept_s, div_zero_s, ovf_s, special_s, sgn_op_s;
  logic [XLEN-1:0]   special_res_s, mag_a_s, mag_b_s;
  logic [2*XLEN-1:0] a_ext_s, b_ext_s, prod_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN:0]     rem_shift_s, diff_s;
  logic [XLEN-1:0]   step_quo_s, step_rem_s, q_fix_s, r_fix_s, div_res_s;
  logic              last_iter_s;

  // Request decode and special-case divide detection on the live operands
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && start && !flush;
    sgn_op_s   = !funct3E[0];
    div_zero_s = (opB == 32'h0000_0000);
    ovf_s      = sgn_op_s && (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
    special_s  = funct3E[2] && (div_zero_s || ovf_s);
    if (div_zero_s) begin
      special_res_s = funct3E[1] ? opA : 32'hFFFF_FFFF;
    end else begin
      special_res_s = funct3E[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
    mag_a_s = (sgn_op_s && opA[31]) ? -opA : opA;
    mag_b_s = (sgn_op_s && opB[31]) ? -opB : opB;
  end

  // Multiplier: sign-extend per op so the low 64 bits of the product are exact
  always_comb begin
    a_ext_s = (funct3_r == 2'b01 || funct3_r == 2'b10) ? {{XLEN{op_a_r[31]}}, op_a_r} : {{XLEN{1'b0}}, op_a_r};
    b_ext_s = (funct3_r == 2'b01) ? {{XLEN{op_b_r[31]}}, op_b_r} : {{XLEN{1'b0}}, op_b_r};
    prod_s  = a_ext_s * b_ext_s;
    if (funct3_r == 2'b00) begin
      mul_res_s = prod_s[XLEN-1:0];
    end else begin
      mul_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // One restoring-division step plus sign fixup of its outcome
  always_comb begin
    rem_shift_s = {rem_r, quo_r[31]};
    diff_s      = rem_shift_s - {1'b0, div_r};
    if (!diff_s[XLEN]) begin
      step_rem_s = diff_s[XLEN-1:0];
      step_quo_s = {quo_r[30:0], 1'b1};
    end else begin
      step_rem_s = rem_shift_s[XLEN-1:0];
      step_quo_s = {quo_r[30:0], 1'b0};
    end
    q_fix_s     = neg_q_r ? -step_quo_s : step_quo_s;
    r_fix_s     = neg_r_r ? -step_rem_s : step_rem_s;
    div_res_s   = funct3_r[1] ? r_fix_s : q_fix_s;
    last_iter_s = (cnt_r == 5'(DIV_ITERS - 1));
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          next_state_s = ST_IDLE;
        end else if (!funct3E[2]) begin
          next_state_s = ST_MUL;
        end else if (special_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DIV;
        end
      end
      ST_MUL:  next_state_s = flush ? ST_IDLE : ST_DONE;
      ST_DIV: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else if (last_iter_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DIV;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op_a_r   <= 32'h0000_0000;
      op_b_r   <= 32'h0000_0000;
      quo_r    <= 32'h0000_0000;
      rem_r    <= 32'h0000_0000;
      div_r    <= 32'h0000_0000;
      result_r <= 32'h0000_0000;
      funct3_r <= 2'b00;
      waddr_r  <= 5'd0;
      waddrm_r <= 5'd0;
      cnt_r    <= 5'd0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      done_r  <= (next_state_s == ST_DONE);
      busy_r  <= (next_state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_a_r   <= opA;
            op_b_r   <= opB;
            funct3_r <= funct3E[1:0];
            waddr_r  <= waddrE;
            quo_r    <= mag_a_s;
            rem_r    <= 32'h0000_0000;
            div_r    <= mag_b_s;
            cnt_r    <= 5'd0;
            neg_q_r  <= sgn_op_s && (opA[31] ^ opB[31]);
            neg_r_r  <= sgn_op_s && opA[31];
            if (special_s) begin
              result_r <= special_res_s;
              waddrm_r <= waddrE;
            end
          end
        end
        ST_MUL: begin
          if (!flush) begin
            result_r <= mul_res_s;
            waddrm_r <= waddr_r;
          end
        end
        ST_DIV: begin
          if (!flush) begin
            quo_r <= step_quo_s;
            rem_r <= step_rem_s;
            cnt_r <= cnt_r + 5'd1;
            if (last_iter_s) begin
              result_r <= div_res_s;
              waddrm_r <= waddr_r;
            end
          end
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Stall must react in the same cycle the request appears
  always_comb begin
    stall = accept_s || (state_r == ST_MUL) || (state_r == ST_DIV);
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign waddrM = waddrm_r;

endmodule

// File: tb/tb_mdu_execute_unit.sv
// Directed self-checking bench for mdu_execute_unit: latency, results,
// special-case divides, flush and mid-operation reset.
module tb_mdu_execute_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3E;
  logic [31:0] opA, opB, result;
  logic [4:0]  waddrE, waddrM;
  logic        stall, busy, done;

  int chk_cnt = 0;
  int err_cnt = 0;

  mdu_execute_unit #(.XLEN(32), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3E(funct3E),
    .opA(opA), .opB(opB), .waddrE(waddrE), .stall(stall), .busy(busy),
    .done(done), .result(result), .waddrM(waddrM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one op at #1 after an edge, hold start until done, then check outputs
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input int exp_lat,
                        input logic [31:0] exp_res);
    int   lat;
    logic stall_ok;
    lat      = 0;
    stall_ok = 1'b1;
    funct3E  = f3; opA = a; opB = b; waddrE = wa; start = 1'b1;
    #1;
    check_eq({tag, "_stall_t"}, 32'(stall), 32'd1);
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      opA = 32'h5A5A_0000 ^ 32'(lat);
      opB = 32'h0000_0003 + 32'(lat);
      if (done) break;
      if (!stall) stall_ok = 1'b0;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_stall_hold"}, 32'(stall_ok), 32'd1);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_waddr"}, 32'(waddrM), 32'(wa));
    check_eq({tag, "_stall_done"}, 32'(stall), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
    check_eq({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int lat;
    int dones;
    rst = 1'b1; start = 1'b0; flush = 1'b1; funct3E = 3'd0;
    opA = 32'd0; opB = 32'd0; waddrE = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0;
    check_eq("reset_out", {26'd0, done, busy, stall, 3'd0}, 32'd0);
    check_eq("reset_res", result, 32'd0);
    check_eq("reset_waddr", 32'(waddrM), 32'd0);

    run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  2,  32'hFFFF_FFEB);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  2,  32'hFFFF_FFFE);
    run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  2,  32'h0000_0000);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  2,  32'hFFFF_FFFF);
    run_op("div",      3'b100, 32'hFFFF_FFEC, 32'd3,        5'd5,  33, 32'hFFFF_FFFA);
    run_op("rem",      3'b110, 32'hFFFF_FFEC, 32'd3,        5'd6,  33, 32'hFFFF_FFFE);
    run_op("divu",     3'b101, 32'd100,      32'd7,        5'd7,  33, 32'd14);
    run_op("remu",     3'b111, 32'd100,      32'd7,        5'd8,  33, 32'd2);
    run_op("divu0",    3'b101, 32'd100,      32'd0,        5'd9,  1,  32'hFFFF_FFFF);
    run_op("remu0",    3'b111, 32'd100,      32'd0,        5'd10, 1,  32'd100);
    run_op("rem0",     3'b110, 32'hFFFF_FFFB, 32'd0,       5'd11, 1,  32'hFFFF_FFFB);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 32'h8000_0000);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'h0000_0000);

    // Flush at t+10 of a divide: no done, result keeps the previous value
    funct3E = 3'b101; opA = 32'd1000; opB = 32'd9; waddrE = 5'd20; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check_eq("flush_stall_t10", 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check_eq("flush_t11", {29'd0, done, busy, stall}, 32'd0);
    check_eq("flush_res", result, 32'h0000_0000);
    check_eq("flush_waddr", 32'(waddrM), 32'd13);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("flush_no_done", 32'(dones), 32'd0);

    run_op("divu_after", 3'b101, 32'd1000, 32'd9, 5'd21, 33, 32'd111);

    // Reset mid-divide together with flush: everything back to zero
    funct3E = 3'b100; opA = 32'hFFFF_FFEC; opB = 32'd3; waddrE = 5'd22; start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    check_eq("rst_mid_out", {29'd0, done, busy, stall}, 32'd0);
    check_eq("rst_mid_res", result, 32'd0);
    check_eq("rst_mid_waddr", 32'(waddrM), 32'd0);

    run_op("mul_after_rst", 3'b000, 32'd12345, 32'd678, 5'd31, 2, 32'd8369910);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
